// File: rtl/sym_cn_lut_mp_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sym_cn_lut_mp_pkg: shared size derivations and loader state encoding
// Rev 1.0
// ---------------------------------------------------------------------------
package sym_cn_lut_mp_pkg;

  function automatic int calc_m(input int quan_size);
    return quan_size - 1;
  endfunction

  function automatic int calc_idx_w(input int quan_size);
    return 2 * (quan_size - 1);
  endfunction

  function automatic int calc_depth(input int quan_size);
    return 1 << calc_idx_w(quan_size);
  endfunction

  function automatic int calc_frame_w(input int frame_num);
    return (frame_num > 1) ? $clog2(frame_num) : 1;
  endfunction

  localparam int         LD_STATE_W = 2;
  localparam logic [1:0] LD_IDLE    = 2'd0;
  localparam logic [1:0] LD_LOAD    = 2'd1;
  localparam logic [1:0] LD_DONE    = 2'd2;

endpackage
`default_nettype wire

// File: rtl/sym_cn_lut_loader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sym_cn_lut_loader: per-frame LUT loader FSM driving the LUT write port
// Rev 1.0
// ---------------------------------------------------------------------------
module sym_cn_lut_loader
  import sym_cn_lut_mp_pkg::*;
#(
  parameter int MULTI_FRAME_NUM = 2,
  parameter int IDX_W           = 4,
  parameter int FRAME_W         = 1,
  parameter int M               = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_start,
  input  logic [FRAME_W-1:0] load_frame,
  input  logic [M-1:0]       lut_wr_data,
  input  logic               lut_wr_valid,
  output logic               lut_wr_ready,
  output logic               load_busy,
  output logic               load_done,
  output logic               wr_en,
  output logic [FRAME_W-1:0] wr_frame,
  output logic [IDX_W-1:0]   wr_idx,
  output logic [M-1:0]       wr_data
);

  localparam int unsigned FRAME_NUM_U = MULTI_FRAME_NUM;

  logic [LD_STATE_W-1:0] state_q, state_d;
  logic [IDX_W-1:0]      cnt_q, cnt_d;
  logic [FRAME_W-1:0]    frame_q, frame_d;
  logic [FRAME_W-1:0]    frame_clamped;

  // Out-of-range frames land on the last frame rather than aliasing
  assign frame_clamped = ({1'b0, load_frame} >= (FRAME_W+1)'(FRAME_NUM_U))
                         ? FRAME_W'(FRAME_NUM_U - 1) : load_frame;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LD_IDLE;
      cnt_q   <= '0;
      frame_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    frame_d = frame_q;
    case (state_q)
      LD_IDLE: begin
        if (load_start) begin
          state_d = LD_LOAD;
          cnt_d   = '0;
          frame_d = frame_clamped;
        end
      end
      LD_LOAD: begin
        if (lut_wr_valid) begin
          cnt_d = cnt_q + IDX_W'(1);
          if (cnt_q == '1) state_d = LD_DONE;
        end
      end
      LD_DONE: state_d = LD_IDLE;
      default: state_d = LD_IDLE;
    endcase
  end

  always_comb begin
    lut_wr_ready = (state_q == LD_LOAD);
    load_busy    = (state_q != LD_IDLE);
    load_done    = (state_q == LD_DONE);
    wr_en        = (state_q == LD_LOAD) && lut_wr_valid;
    wr_frame     = frame_q;
    wr_idx       = cnt_q;
    wr_data      = lut_wr_data;
  end

endmodule
`default_nettype wire

// File: rtl/sym_cn_lut_mp.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sym_cn_lut_mp: multi-port, multi-frame symmetric check-node LUT with a
// 2-stage stallable read pipeline and an integrated per-frame loader.
// Rev 1.0
// ---------------------------------------------------------------------------
module sym_cn_lut_mp
  import sym_cn_lut_mp_pkg::*;
#(
  parameter int  QUAN_SIZE       = 3,
  parameter int  PORT_NUM        = 4,
  parameter int  MULTI_FRAME_NUM = 2,
  parameter int  SYM_FOLD        = 1,
  localparam int M               = calc_m(QUAN_SIZE),
  localparam int IDX_W           = calc_idx_w(QUAN_SIZE),
  localparam int DEPTH           = calc_depth(QUAN_SIZE),
  localparam int FRAME_W         = calc_frame_w(MULTI_FRAME_NUM)
) (
  input  logic                          read_clk,
  input  logic                          rst,
  input  logic                          pipe_en,
  input  logic                          in_valid,
  input  logic [PORT_NUM*QUAN_SIZE-1:0] y0_in,
  input  logic [PORT_NUM*QUAN_SIZE-1:0] y1_in,
  input  logic [FRAME_W-1:0]            read_addr_offset,
  output logic [PORT_NUM*QUAN_SIZE-1:0] t_c_out,
  output logic                          out_valid,
  output logic [FRAME_W-1:0]            read_addr_offset_out,
  input  logic                          load_start,
  input  logic [FRAME_W-1:0]            load_frame,
  input  logic [M-1:0]                  lut_wr_data,
  input  logic                          lut_wr_valid,
  output logic                          lut_wr_ready,
  output logic                          load_busy,
  output logic                          load_done
);

  logic [M-1:0] lut_mem [MULTI_FRAME_NUM*DEPTH];

  logic               wr_en;
  logic [FRAME_W-1:0] wr_frame;
  logic [IDX_W-1:0]   wr_idx;
  logic [M-1:0]       wr_data;

  logic [PORT_NUM*IDX_W-1:0] fold_addr;
  logic [PORT_NUM-1:0]       fold_sign;

  logic [PORT_NUM*IDX_W-1:0] addr_s0_q, addr_s0_d;
  logic [PORT_NUM-1:0]       sign_s0_q, sign_s0_d;
  logic                      valid_s0_q, valid_s0_d;
  logic [FRAME_W-1:0]        tag_s0_q, tag_s0_d;
  logic [PORT_NUM*M-1:0]     data_s1_q, data_s1_d;
  logic [PORT_NUM-1:0]       sign_s1_q, sign_s1_d;
  logic                      valid_s1_q, valid_s1_d;
  logic [FRAME_W-1:0]        tag_s1_q, tag_s1_d;

  sym_cn_lut_loader #(
    .MULTI_FRAME_NUM (MULTI_FRAME_NUM),
    .IDX_W           (IDX_W),
    .FRAME_W         (FRAME_W),
    .M               (M)
  ) u_loader (
    .clk          (read_clk),
    .rst          (rst),
    .load_start   (load_start),
    .load_frame   (load_frame),
    .lut_wr_data  (lut_wr_data),
    .lut_wr_valid (lut_wr_valid),
    .lut_wr_ready (lut_wr_ready),
    .load_busy    (load_busy),
    .load_done    (load_done),
    .wr_en        (wr_en),
    .wr_frame     (wr_frame),
    .wr_idx       (wr_idx),
    .wr_data      (wr_data)
  );

  for (genvar k = 0; k < PORT_NUM; k++) begin : g_ch
    logic [QUAN_SIZE-1:0] y0, y1;
    logic [M-1:0]         i0, i1;
    assign y0 = y0_in[k*QUAN_SIZE +: QUAN_SIZE];
    assign y1 = y1_in[k*QUAN_SIZE +: QUAN_SIZE];
    if (SYM_FOLD != 0) begin : g_sym
      assign i0 = ~y0[M-1:0];
      assign i1 = y1[QUAN_SIZE-1] ? ~y1[M-1:0] : y1[M-1:0];
    end else begin : g_raw
      assign i0 = y0[M-1:0];
      assign i1 = y1[M-1:0];
    end
    assign fold_addr[k*IDX_W +: IDX_W] = {i0, i1};
    assign fold_sign[k] = ~(y0[QUAN_SIZE-1] ^ y1[QUAN_SIZE-1]);
    assign t_c_out[k*QUAN_SIZE +: QUAN_SIZE] = {sign_s1_q[k], data_s1_q[k*M +: M]};
  end

  // Loader writes are independent of pipe_en; a same-address read sees old data
  always_ff @(posedge read_clk) begin
    if (wr_en) lut_mem[{wr_frame, wr_idx}] <= wr_data;
  end

  always_comb begin
    addr_s0_d  = addr_s0_q;
    sign_s0_d  = sign_s0_q;
    valid_s0_d = valid_s0_q;
    tag_s0_d   = tag_s0_q;
    data_s1_d  = data_s1_q;
    sign_s1_d  = sign_s1_q;
    valid_s1_d = valid_s1_q;
    tag_s1_d   = tag_s1_q;
    if (pipe_en) begin
      addr_s0_d  = fold_addr;
      sign_s0_d  = fold_sign;
      valid_s0_d = in_valid;
      tag_s0_d   = read_addr_offset;
      sign_s1_d  = sign_s0_q;
      valid_s1_d = valid_s0_q;
      tag_s1_d   = tag_s0_q;
      for (int k = 0; k < PORT_NUM; k++) begin
        data_s1_d[k*M +: M] = lut_mem[{tag_s0_q, addr_s0_q[k*IDX_W +: IDX_W]}];
      end
    end
  end

  always_ff @(posedge read_clk) begin
    if (rst) begin
      addr_s0_q  <= '0;
      sign_s0_q  <= '0;
      valid_s0_q <= 1'b0;
      tag_s0_q   <= '0;
      data_s1_q  <= '0;
      sign_s1_q  <= '0;
      valid_s1_q <= 1'b0;
      tag_s1_q   <= '0;
    end else begin
      addr_s0_q  <= addr_s0_d;
      sign_s0_q  <= sign_s0_d;
      valid_s0_q <= valid_s0_d;
      tag_s0_q   <= tag_s0_d;
      data_s1_q  <= data_s1_d;
      sign_s1_q  <= sign_s1_d;
      valid_s1_q <= valid_s1_d;
      tag_s1_q   <= tag_s1_d;
    end
  end

  assign out_valid            = valid_s1_q;
  assign read_addr_offset_out = tag_s1_q;

endmodule
`default_nettype wire
